hack_screen_scanner: RTL
========================

// Module: hack_screen_scanner
// PURPOSE
// - Video source for the Nand2Tetris core. Scans the 512x256 monochrome Hack screen memory
//   (8192 x 16-bit words, Hack address 0x4000 base) and produces pixel-enable, blank, sync and 8-bit video.
// - Feeds the core top-level video outputs.
// - Centres the Hack screen in a 640x480 raster and fills the surround with a border level.
// PARAMETERS
// - H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48: horizontal timing, in pixels.
// - V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33: vertical timing, in lines.
// - X_OFF 64: first active column of the Hack window. Must be >= 8.
// - Y_OFF 112: first active line of the Hack window.
// - CE_DIV 4: clk cycles per pixel. Must be >= 2.
// - BORDER 8'h40: video level outside the window during active display.
// PORTS
// - clk          in   1   system clock.
// - reset_n      in   1   asynchronous, active-low reset.
// - ce_pix       out  1   one-clk pulse every CE_DIV clks; all other outputs change only on ce_pix.
// - HBlank       out  1   high outside the H_ACTIVE columns.
// - HSync        out  1   high during the H_SYNC pulse (active-high).
// - VBlank       out  1   high outside the V_ACTIVE lines.
// - VSync        out  1   high during the V_SYNC lines (active-high).
// - video        out  8   grey level: 8'h00 for Hack bit=1 (black), 8'hFF for bit=0, BORDER outside the window, 0 in blank.
// - screen_addr  out  13  word address into screen RAM: 32*row + col/16.
// - screen_rd    out  1   one-clk read strobe.
// - screen_data  in   16  read data, valid exactly 1 clk after screen_rd.
// - frame_start  out  1   one-clk pulse coincident with the ce_pix where hc=0, vc=0.
// BEHAVIOUR
// - Reset values (async on reset_n low): ce_pix=0, HBlank=1, VBlank=1, HSync=0, VSync=0, video=0,
//   screen_rd=0, screen_addr=0, frame_start=0. Counters hc=vc=0; CE divider and shift register cleared.
// - Reset mid-frame: outputs go to reset values immediately. After release, scanning restarts at hc=0, vc=0.
//   The first ce_pix occurs CE_DIV clks after release.
// - Counters:
//   - hc counts 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
//   - vc counts 0..VT-1, where VT = 525.
//   - Both advance only on ce_pix. hc wraps to 0 and increments vc; vc wraps to 0 at VT-1.
//   - Simultaneous hc and vc wrap starts a new frame.
// - Window: row = vc - Y_OFF, in 0..255; col = hc - X_OFF, in 0..511. Word k = col>>4, in 0..31.
// - Fetch:
//   - On the ce_pix where hc = X_OFF + 16k - 8 and vc is inside the window, assert screen_rd for 1 clk
//     with screen_addr = {row[7:0], k[4:0]}.
//   - Capture screen_data into a hold register on the following clk.
//   - Load the hold register into a 16-bit shift register on the ce_pix where hc = X_OFF + 16k - 1.
// - Pixel order: bit 0 of a word is the leftmost pixel. The shift register shifts right once per ce_pix.
// - Output pipeline:
//   - video, blank, sync and frame_start are registered from the current hc/vc, giving a uniform
//     1-pixel latency between counter state and outputs.
//   - Blank and sync stay aligned with video; there is no skew between them.
// - Sync windows:
//   - HSync while hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - VSync while vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
// - No read outside the window. No read during blank. Exactly 32 reads per window line; 8192 per frame.
// - screen_data is ignored except on the capture clk.
// STRUCTURE
// - Package hack_video_pkg holds:
//   - timing constants (HT, VT, sync start/end);
//   - HACK_W=512, HACK_H=256, WORDS_PER_ROW=32;
//   - typedef screen_addr_t (logic [12:0]).
// - Sub-module hack_video_timing: CE divider, hc/vc counters, blank/sync decode.
// - The top instance adds the fetch/shift datapath.
// TESTING
// - Reset release: ce_pix first high at clk CE_DIV after release. HBlank=VBlank=1 until hc=0, vc=0 is output.
//   frame_start pulses once per 800*525 ce_pix.
// - Timing: count ce_pix between HSync rising edges = 800. HSync width = 96. VSync width = 2 lines.
//   VBlank high for 45 lines.
// - Pattern: RAM word(32*r+k) = 16'h0001 for all r, k.
//   -> video=00 at col = 16k, and FF at the other 15 columns of each word.
//   -> Column 0 appears at output hc = 65 (X_OFF + 1 pipeline).
// - Address sequence: log screen_rd per frame.
//   -> Exactly 8192 strobes; addresses 0..8191 ascending.
//   -> First strobe on line vc=112; last address 8191 on vc=367.
// - Border: all-zero RAM.
//   -> Window pixels = FF; active pixels outside the window = 8'h40; blank pixels = 00.
// - Mid-frame reset at vc=200, hc=300: outputs return to reset values within the same clk.
//   After release, the next frame_start occurs on the first ce_pix, and the pattern is undisturbed in the next frame.

Source files
------------

// File: rtl/hack_video_pkg.sv
// ---------------------------------------------------------------------------
// hack_video_pkg
// Shared constants and types for the Hack screen scanner: 640x480 raster
// timing (in pixels and lines), Hack screen geometry and the screen RAM
// address type.
// ---------------------------------------------------------------------------
package hack_video_pkg;

  // Horizontal timing, pixels.
  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int HT           = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing, lines.
  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int VT           = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Hack screen geometry.
  localparam int HACK_W        = 512;
  localparam int HACK_H        = 256;
  localparam int WORDS_PER_ROW = 32;

  // Width of the hc/vc counters (both ranges fit in 10 bits).
  localparam int CNT_W = 10;

  typedef logic [12:0] screen_addr_t;

endpackage

// File: rtl/hack_video_timing.sv
// ---------------------------------------------------------------------------
// hack_video_timing
// Pixel clock-enable divider, horizontal/vertical counters and registered
// blank/sync/frame_start decode for the 640x480 raster.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   ce_pre         combinational: ce_pix will be high in the next clk
//   ce_pix         one-clk pulse every CE_DIV clks
//   hc, vc         current column / line (change at the end of a ce_pix clk)
//   HBlank, HSync  horizontal blank / sync, 1 pixel behind hc
//   VBlank, VSync  vertical blank / sync, 1 pixel behind vc
//   frame_start    high during the ce_pix clk where hc=0, vc=0
// ---------------------------------------------------------------------------
module hack_video_timing
  import hack_video_pkg::*;
#(
  parameter int CE_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             ce_pre,
  output logic             ce_pix,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             HBlank,
  output logic             HSync,
  output logic             VBlank,
  output logic             VSync,
  output logic             frame_start
);

  localparam int DIV_W = $clog2(CE_DIV);

  logic [DIV_W-1:0] div_cnt;

  // ce_pix is registered, so it is announced one clk early; this lets
  // frame_start and the screen fetch line up with the ce_pix clk itself.
  assign ce_pre = (div_cnt == DIV_W'(CE_DIV - 1));

  // NOTE: every register in a clocked block is assigned with <= so all of
  // them see the pre-edge values of hc/vc, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      ce_pix      <= 1'b0;
      frame_start <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      HBlank      <= 1'b1;
      HSync       <= 1'b0;
      VBlank      <= 1'b1;
      VSync       <= 1'b0;
    end else begin
      div_cnt     <= ce_pre ? '0 : div_cnt + 1'b1;
      ce_pix      <= ce_pre;
      frame_start <= ce_pre && (hc == '0) && (vc == '0);

      if (ce_pix) begin
        // Decode from the current counters: one pixel of latency, the same
        // as the video path in the top level.
        HBlank <= (hc >= CNT_W'(H_ACTIVE));
        HSync  <= (hc >= CNT_W'(H_SYNC_START)) && (hc < CNT_W'(H_SYNC_END));
        VBlank <= (vc >= CNT_W'(V_ACTIVE));
        VSync  <= (vc >= CNT_W'(V_SYNC_START)) && (vc < CNT_W'(V_SYNC_END));

        if (hc == CNT_W'(HT - 1)) begin
          hc <= '0;
          vc <= (vc == CNT_W'(VT - 1)) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hack_screen_scanner.sv
// ---------------------------------------------------------------------------
// hack_screen_scanner
// Scans the 512x256 Hack screen RAM and produces 640x480 video with the
// Hack window at (X_OFF, Y_OFF) and a BORDER level around it.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   ce_pix         pixel clock enable (one clk in CE_DIV)
//   HBlank, HSync  horizontal blank / sync (active high)
//   VBlank, VSync  vertical blank / sync (active high)
//   video          8-bit grey: 00 for a set Hack bit, FF for clear, BORDER
//                  outside the window, 00 in blank
//   screen_addr    word address {row, word}, held between reads
//   screen_rd      one-clk read strobe; screen_data is valid one clk later
//   screen_data    screen RAM read data
//   frame_start    high during the ce_pix clk where hc=0, vc=0
// ---------------------------------------------------------------------------
module hack_screen_scanner
  import hack_video_pkg::*;
#(
  parameter int          X_OFF  = 64,
  parameter int          Y_OFF  = 112,
  parameter int          CE_DIV = 4,
  parameter logic [7:0]  BORDER = 8'h40
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ce_pix,
  output logic        HBlank,
  output logic        HSync,
  output logic        VBlank,
  output logic        VSync,
  output logic [7:0]  video,
  output logic [12:0] screen_addr,
  output logic        screen_rd,
  input  logic [15:0] screen_data,
  output logic        frame_start
);

  logic             ce_pre;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;

  hack_video_timing #(
    .CE_DIV (CE_DIV)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_pre      (ce_pre),
    .ce_pix      (ce_pix),
    .hc          (hc),
    .vc          (vc),
    .HBlank      (HBlank),
    .HSync       (HSync),
    .VBlank      (VBlank),
    .VSync       (VSync),
    .frame_start (frame_start)
  );

  // Window-relative coordinates. One extra bit so positions left of / above
  // the window wrap to large values and fail the range compares.
  logic [CNT_W:0] col;        // column of the pixel at hc
  logic [CNT_W:0] col_fetch;  // column 8 pixels ahead: word fetch point
  logic [CNT_W:0] col_load;   // column 1 pixel ahead: shift register load
  logic [CNT_W:0] row;
  logic           in_rows;
  logic           in_window;
  logic           fetch_hit;
  logic           load_hit;
  screen_addr_t   fetch_addr;

  // NOTE: the decode is pure continuous assignment, so nothing here can be
  // held over from a previous cycle and no latch can be inferred.
  assign col        = {1'b0, hc} - (CNT_W + 1)'(X_OFF);
  assign col_fetch  = {1'b0, hc} + (CNT_W + 1)'(8) - (CNT_W + 1)'(X_OFF);
  assign col_load   = {1'b0, hc} + (CNT_W + 1)'(1) - (CNT_W + 1)'(X_OFF);
  assign row        = {1'b0, vc} - (CNT_W + 1)'(Y_OFF);
  assign in_rows    = (row < (CNT_W + 1)'(HACK_H));
  assign in_window  = in_rows && (col < (CNT_W + 1)'(HACK_W));
  assign fetch_hit  = in_rows && (col_fetch < (CNT_W + 1)'(HACK_W)) &&
                      (col_fetch[3:0] == 4'd0);
  assign load_hit   = in_rows && (col_load < (CNT_W + 1)'(HACK_W)) &&
                      (col_load[3:0] == 4'd0);
  assign fetch_addr = {row[7:0], col_fetch[8:4]};

  logic        rd_d;     // screen_data is valid while this is high
  logic [15:0] hold;     // fetched word waiting for its load point
  logic [15:0] shifter;  // bit 0 is the pixel about to be shown

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      screen_rd   <= 1'b0;
      screen_addr <= '0;
      rd_d        <= 1'b0;
      hold        <= '0;
      shifter     <= '0;
      video       <= '0;
    end else begin
      // Like ce_pix, the strobe is launched from ce_pre so it coincides
      // with the ce_pix clk of the fetch column.
      screen_rd <= ce_pre && fetch_hit;
      if (ce_pre && fetch_hit) begin
        screen_addr <= fetch_addr;
      end

      rd_d <= screen_rd;
      if (rd_d) begin
        hold <= screen_data;
      end

      if (ce_pix) begin
        // The word fetched 8 pixels earlier is loaded just before its first
        // column, and the previous word has fully shifted out by then.
        shifter <= load_hit ? hold : {1'b0, shifter[15:1]};

        if ((hc >= CNT_W'(H_ACTIVE)) || (vc >= CNT_W'(V_ACTIVE))) begin
          video <= 8'h00;
        end else if (in_window) begin
          video <= shifter[0] ? 8'h00 : 8'hFF;
        end else begin
          video <= BORDER;
        end
      end
    end
  end

endmodule
